// File: rtl/branch_pred.sv
// branch_pred: 2-bit saturating-counter branch predictor, predicts at fetch, resolves/trains at decode
//
// Optional feature: define BP_GSHARE_EN to XOR an INDEX_W-bit global history into the fetch index.
//
// Ports:
//   clk, rst            pipeline clock, synchronous active-high reset
//   f_pc, f_valid       fetch-stage PC and valid
//   f_pred_taken        prediction for the fetch instruction (combinational)
//   stall_d, flush_d    IF/ID hold and invalidate
//   d_is_branch         decode instruction is a conditional branch
//   d_taken             actual outcome from the decode comparator
//   d_pred_taken        prediction carried with the decode instruction
//   mispredict          decode branch outcome differs from its prediction
//   mispredict_taken    redirect direction: 1 = branch target, 0 = fall-through
//   stat_branches       saturating count of resolved branches
//   stat_mispredicts    saturating count of mispredictions
module branch_pred #(
    parameter int INDEX_W = 6,
    parameter int STAT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       f_pc,
    input  logic              f_valid,
    output logic              f_pred_taken,
    input  logic              stall_d,
    input  logic              flush_d,
    input  logic              d_is_branch,
    input  logic              d_taken,
    output logic              d_pred_taken,
    output logic              mispredict,
    output logic              mispredict_taken,
    output logic [STAT_W-1:0] stat_branches,
    output logic [STAT_W-1:0] stat_mispredicts
);
    localparam int N = 1 << INDEX_W;

    logic [1:0]         cnt_q [N];
    logic               d_valid_q, d_valid_d;
    logic [INDEX_W-1:0] d_idx_q, d_idx_d;
    logic               d_pred_q, d_pred_d;
    logic [STAT_W-1:0]  br_q, br_d, mp_q, mp_d;
    logic [INDEX_W-1:0] f_idx;
    logic [1:0]         cur, upd;
    logic               res;
    logic               unused_pc;

    assign unused_pc = ^{f_pc[31:INDEX_W+2], f_pc[1:0]};

`ifdef BP_GSHARE_EN
    logic [INDEX_W-1:0] ghr_q, ghr_d;
    assign f_idx = f_pc[INDEX_W+1:2] ^ ghr_q;
    assign ghr_d = res ? {ghr_q[INDEX_W-2:0], d_taken} : ghr_q;
    always_ff @(posedge clk)
        ghr_q <= rst ? '0 : ghr_d;
`else
    assign f_idx = f_pc[INDEX_W+1:2];
`endif

    // No bypass: a same-cycle training write is not visible to this read.
    assign f_pred_taken     = f_valid & cnt_q[f_idx][1];
    assign d_pred_taken     = d_pred_q;
    assign res              = d_valid_q & d_is_branch & ~stall_d;
    assign mispredict       = res & (d_taken != d_pred_q);
    assign mispredict_taken = mispredict & d_taken;
    assign stat_branches    = br_q;
    assign stat_mispredicts = mp_q;

    assign cur = cnt_q[d_idx_q];
    assign upd = d_taken ? (cur == 2'd3 ? cur : cur + 2'd1)
                         : (cur == 2'd0 ? cur : cur - 2'd1);

    always_comb begin
        d_valid_d = flush_d ? 1'b0 : stall_d ? d_valid_q : f_valid;
        d_idx_d   = flush_d ? '0   : stall_d ? d_idx_q   : f_idx;
        d_pred_d  = flush_d ? 1'b0 : stall_d ? d_pred_q  : f_pred_taken;
        br_d      = (res & ~&br_q) ? br_q + 1'b1 : br_q;
        mp_d      = (mispredict & ~&mp_q) ? mp_q + 1'b1 : mp_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++)
                cnt_q[i] <= 2'd1;
            d_valid_q <= 1'b0;
            d_idx_q   <= '0;
            d_pred_q  <= 1'b0;
            br_q      <= '0;
            mp_q      <= '0;
        end else begin
            if (res)
                cnt_q[d_idx_q] <= upd;
            d_valid_q <= d_valid_d;
            d_idx_q   <= d_idx_d;
            d_pred_q  <= d_pred_d;
            br_q      <= br_d;
            mp_q      <= mp_d;
        end
    end
endmodule

// File: tb/tb_branch_pred.sv
// tb_branch_pred: randomized scoreboard bench for branch_pred against a behavioural predictor model
module tb_branch_pred;
    localparam int IW = 6;
    localparam int SW = 4;
    localparam int N  = 1 << IW;
    localparam int SMAX = (1 << SW) - 1;

    logic          clk = 0;
    logic          rst, f_valid, stall_d, flush_d, d_is_branch, d_taken;
    logic [31:0]   f_pc;
    logic          f_pred_taken, d_pred_taken, mispredict, mispredict_taken;
    logic [SW-1:0] stat_branches, stat_mispredicts;

    branch_pred #(.INDEX_W(IW), .STAT_W(SW)) dut (
        .clk(clk), .rst(rst), .f_pc(f_pc), .f_valid(f_valid), .f_pred_taken(f_pred_taken),
        .stall_d(stall_d), .flush_d(flush_d), .d_is_branch(d_is_branch), .d_taken(d_taken),
        .d_pred_taken(d_pred_taken), .mispredict(mispredict), .mispredict_taken(mispredict_taken),
        .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          fp, dp, mp, mt;
        logic [SW-1:0] sb, sm;
    } exp_t;
    exp_t q[$];

    int vectors = 0;
    int errors  = 0;

    // Reference model: counters as plain integers, record as the last accepted fetch.
    int cnt[N];
    int ghr, dv, didx, dpred, sb, sm;

    function automatic void model_reset();
        for (int i = 0; i < N; i++) cnt[i] = 1;
        ghr = 0; dv = 0; didx = 0; dpred = 0; sb = 0; sm = 0;
    endfunction

    task automatic step(input logic [31:0] pc, input bit fv, st, fl, br, tk, r);
        int fidx, fp, res, mp;
        exp_t e;
        @(posedge clk);
        #1;
        f_pc = pc; f_valid = fv; stall_d = st; flush_d = fl;
        d_is_branch = br; d_taken = tk; rst = r;
        fidx = (pc >> 2) % N;
`ifdef BP_GSHARE_EN
        fidx = fidx ^ ghr;
`endif
        fp  = (fv && cnt[fidx] >= 2) ? 1 : 0;
        res = (dv && br && !st) ? 1 : 0;
        mp  = (res && (tk != dpred)) ? 1 : 0;
        e.fp = fp[0]; e.dp = dpred[0]; e.mp = mp[0]; e.mt = mp[0] & tk;
        e.sb = sb[SW-1:0]; e.sm = sm[SW-1:0];
        q.push_back(e);
        if (r) begin
            model_reset();
        end else begin
            if (res) begin
                cnt[didx] = tk ? (cnt[didx] < 3 ? cnt[didx] + 1 : 3) : (cnt[didx] > 0 ? cnt[didx] - 1 : 0);
                sb  = sb < SMAX ? sb + 1 : SMAX;
                ghr = ((ghr << 1) | int'(tk)) % N;
            end
            if (mp) sm = sm < SMAX ? sm + 1 : SMAX;
            if (fl) begin
                dv = 0; didx = 0; dpred = 0;
            end else if (!st) begin
                dv = fv; didx = fidx; dpred = fp;
            end
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e, g;
            e = q.pop_front();
            g = {f_pred_taken, d_pred_taken, mispredict, mispredict_taken, stat_branches, stat_mispredicts};
            vectors++;
            if (g !== e)
                $display("FAIL outputs @%0t: got fp=%b dp=%b mp=%b mt=%b sb=%0d sm=%0d, need fp=%b dp=%b mp=%b mt=%b sb=%0d sm=%0d",
                         $time, g.fp, g.dp, g.mp, g.mt, g.sb, g.sm, e.fp, e.dp, e.mp, e.mt, e.sb, e.sm);
            if (g !== e) errors++;
        end
    end

    initial begin
        logic [31:0] p;
        p = 32'h0040_0010;
        rst = 1; f_pc = p; f_valid = 1; stall_d = 0; flush_d = 0; d_is_branch = 0; d_taken = 0;
        model_reset();
        repeat (2) @(posedge clk);
        step(p, 1, 0, 0, 0, 0, 1);
        step(p, 1, 0, 0, 0, 0, 0);
        step(p, 1, 0, 0, 1, 1, 0);
        step(p, 1, 0, 0, 1, 1, 0);
        step(p, 1, 0, 0, 1, 1, 0);
        step(p, 1, 0, 0, 1, 0, 0);
        step(p, 1, 0, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) step(p, 1, 1, 0, 1, 1, 0);
        step(p, 1, 0, 0, 1, 1, 0);
        step(p, 1, 1, 1, 1, 1, 0);
        step(p, 1, 0, 0, 1, 1, 0);
        for (int i = 0; i < 6; i++) step(p, 1, 0, 0, 1, 0, 0);
        step(p, 0, 0, 0, 1, 0, 0);
        step(p, 1, 0, 0, 0, 1, 0);
        for (int i = 0; i < 20; i++) step(p, 1, 0, 0, 1, 1, 0);
        step(p, 1, 0, 0, 0, 0, 1);
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] rp;
            rp = ($urandom_range(0, 3) == 0) ? $urandom : 32'h0040_0000 + ($urandom_range(0, 15) << 2);
            step(rp, $urandom_range(0, 7) != 0, $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 299) == 0);
        end
        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        if (q.size() != 0) begin
            $display("FAIL drain: %0d expected responses never checked, need 0", q.size());
            errors++;
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
